dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences MEM-stage data-memory accesses for the 5-stage MIPS32 pipeline.
//  - Consumes decoder controls: MemRead, MemWrite, MemWidth, SignExtend_Dmemory_out.
//  - Drives a word-wide req/ack data bus with byte enables; stalls the pipeline until done.
//  - Returns aligned, sign- or zero-extended load data; flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  255  BUSY cycles without bus_ack_i before abort with err_o (1..255)
//  BIG_ENDIAN      0    0: byte k of word -> lane k; 1: byte k -> lane 3-k
// PORTS
//  clk           in   1   sole clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  mem_read_i    in   1   MemRead from EX/MEM register
//  mem_write_i   in   1   MemWrite from EX/MEM register
//  mem_width_i   in   2   00 byte, 01 half, 10 word; 11 treated as word
//  sign_ext_i    in   1   1: sign-extend load data, 0: zero-extend
//  addr_i        in   32  effective address (ALU result)
//  wdata_i       in   32  store data (rt value)
//  stall_o       out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  rdata_o       out  32  extended load data, valid while done_o=1
//  done_o        out  1   one-cycle pulse: access complete, pipeline advances
//  misalign_o    out  1   with done_o: address misaligned, no bus cycle issued
//  err_o         out  1   with done_o: bus timeout
//  bus_req_o     out  1   request, held high until ack
//  bus_we_o      out  1   1 write, 0 read
//  bus_addr_o    out  32  word address, {addr_i[31:2],2'b00}
//  bus_be_o      out  4   byte-lane enables
//  bus_wdata_o   out  32  lane-replicated store data
//  bus_ack_i     in   1   one-cycle completion strobe from memory
//  bus_rdata_i   in   32  read data, valid with bus_ack_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: acc = mem_read_i|mem_write_i. If acc and aligned -> latch addr/width/sign/lane,
//     drive bus_* registered -> BUSY. If acc and misaligned -> DONE with misalign_o=1
//     and no bus cycle. Otherwise stay in IDLE.
//   BUSY: bus_req_o=1; bus_addr/we/be/wdata are stable. Counter increments each cycle.
//     On bus_ack_i: capture bus_rdata_i -> DONE; bus_req_o drops the next cycle.
//     If the counter reaches TIMEOUT_CYCLES without ack: -> DONE, err_o=1, rdata_o=0.
//   DONE: done_o=1 for one cycle; rdata_o/misalign_o/err_o valid; -> IDLE unconditionally.
//     Inputs are ignored in DONE, so the same instruction is never reissued.
//  stall_o is combinational: (IDLE & acc) | BUSY; low in DONE.
//  Latency: ack in the first BUSY cycle gives stall of 2 cycles and done_o 2 cycles after IDLE.
//   Misaligned access: stall of 1 cycle.
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0; bytes never misaligned.
//  mem_read_i and mem_write_i both high: treat as a write.
//  Lanes (BIG_ENDIAN=0), k=addr[1:0]:
//   byte: be=1<<k; wdata={4{wdata_i[7:0]}}.
//   half: be = k[1] ? 1100 : 0011; wdata={2{wdata_i[15:0]}}.
//   word: be=1111.
//  Read extract: select the byte/half at the latched lane, extend to 32 bits per the latched sign.
//   Word loads pass through unchanged. Stores leave rdata_o=0.
//  bus_ack_i in IDLE or DONE is spurious and ignored.
//  rst during BUSY: abort, bus_req_o=0 next cycle, no done_o.
// STRUCTURE
//  Add to mips_defines.vh: MEMW_BYTE/HALF/WORD (2'b00/01/10) and DMEM_IDLE/BUSY/DONE encodings.
//  Sub-module dmem_lane_align (combinational): width, addr[1:0], wdata -> be, wdata lanes;
//   width, lane, sign, rdata -> extended load data.
//  FSM, latches and timeout counter stay in dmem_access_ctrl.
// TESTING
//  lw addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> be=1111, stall 4 cycles, rdata_o=0xDEADBEEF.
//  lb addr 0x103, rdata 0x80xxxxxx, sign=1 -> be=1000, rdata_o=0xFFFFFF80; lbu -> 0x00000080.
//  sh addr 0x102, wdata 0x1234ABCD -> be=1100, bus_wdata=0xABCDABCD, bus_addr=0x100.
//  lw addr 0x101 -> no bus_req_o, done_o+misalign_o one cycle after request, stall 1 cycle.
//  No ack with TIMEOUT_CYCLES=4 -> req held 4 cycles, then done_o+err_o, rdata_o=0.
//  rst in 2nd BUSY cycle -> bus_req_o=0 next cycle, no done_o; next lw completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared width codes, FSM state encoding and the alignment rule for the
// MEM-stage data-memory access controller.
package dmem_access_ctrl_pkg;

  localparam logic [1:0] MEMW_BYTE = 2'b00;
  localparam logic [1:0] MEMW_HALF = 2'b01;
  localparam logic [1:0] MEMW_WORD = 2'b10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_BUSY = 2'b01,
    DMEM_DONE = 2'b10
  } dmem_state_t;

  // Width code 11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      MEMW_BYTE: is_misaligned = 1'b0;
      MEMW_HALF: is_misaligned = lo[0];
      default:   is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated store data,
// and load-data extraction with sign or zero extension.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  input  logic [1:0]  rd_width,
  input  logic [1:0]  rd_lane,
  input  logic        rd_sign,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [1:0]  phys;
  logic [1:0]  rd_phys;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Big-endian mirrors the byte index; for halves only bit 1 matters.
  always_comb begin
    phys        = (BIG_ENDIAN != 0) ? ~lane : lane;
    be          = 4'b1111;
    wdata_lanes = wdata;
    case (width)
      MEMW_BYTE: begin
        be          = 4'b0001 << phys;
        wdata_lanes = {4{wdata[7:0]}};
      end
      MEMW_HALF: begin
        be          = phys[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      MEMW_WORD: ;
      default: ;
    endcase
  end

  always_comb begin
    rd_phys   = (BIG_ENDIAN != 0) ? ~rd_lane : rd_lane;
    rd_byte   = rdata[{rd_phys, 3'b000} +: 8];
    rd_half   = rd_phys[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (rd_width)
      MEMW_BYTE: load_data = {{24{rd_sign & rd_byte[7]}}, rd_byte};
      MEMW_HALF: load_data = {{16{rd_sign & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack bus cycle per load or
// store, stalls the pipeline until it completes, flags misalignment and timeout.
//
//  state     | meaning
//  DMEM_IDLE | waiting for MemRead/MemWrite; misaligned requests go straight to DONE
//  DMEM_BUSY | bus_req_o held, counting cycles until bus_ack_i or timeout
//  DMEM_DONE | one-cycle done_o with result flags; inputs ignored
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int BIG_ENDIAN     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_width_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  dmem_state_t state, state_n;
  logic [7:0]  tmo_cnt;
  logic [1:0]  width_q;
  logic [1:0]  lane_q;
  logic        sign_q;
  logic        acc;
  logic        misal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;

  assign acc     = mem_read_i | mem_write_i;
  assign misal   = is_misaligned(mem_width_i, addr_i[1:0]);
  assign stall_o = ((state == DMEM_IDLE) && acc) || (state == DMEM_BUSY);
  assign done_o  = (state == DMEM_DONE);

  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .width       (mem_width_i),
    .lane        (addr_i[1:0]),
    .wdata       (wdata_i),
    .be          (be_c),
    .wdata_lanes (wdata_c),
    .rd_width    (width_q),
    .rd_lane     (lane_q),
    .rd_sign     (sign_q),
    .rdata       (bus_rdata_i),
    .load_data   (load_c)
  );

  always_comb begin
    state_n = state;
    case (state)
      DMEM_IDLE: if (acc) state_n = misal ? DMEM_DONE : DMEM_BUSY;
      DMEM_BUSY: if (bus_ack_i || (tmo_cnt == TMO_LAST)) state_n = DMEM_DONE;
      DMEM_DONE: state_n = DMEM_IDLE;
      default:   state_n = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DMEM_IDLE;
      tmo_cnt     <= 8'd0;
      width_q     <= 2'b00;
      lane_q      <= 2'b00;
      sign_q      <= 1'b0;
      rdata_o     <= 32'd0;
      misalign_o  <= 1'b0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= 32'd0;
    end else begin
      state <= state_n;
      case (state)
        DMEM_IDLE: begin
          if (acc && !misal) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_write_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= be_c;
            bus_wdata_o <= wdata_c;
            width_q     <= mem_width_i;
            lane_q      <= addr_i[1:0];
            sign_q      <= sign_ext_i;
            tmo_cnt     <= 8'd0;
          end else if (acc) begin
            misalign_o <= 1'b1;
          end
        end
        DMEM_BUSY: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // Ack on the last allowed cycle still counts as a completion.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            rdata_o   <= bus_we_o ? 32'd0 : load_c;
          end else if (tmo_cnt == TMO_LAST) begin
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
          end
        end
        default: begin
          rdata_o    <= 32'd0;
          misalign_o <= 1'b0;
          err_o      <= 1'b0;
          tmo_cnt    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized
// accesses compared against a byte-addressed reference model.
module tb_dmem_access_ctrl;

  localparam int T  = 4;
  localparam int BE = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, sign_ext;
  logic [1:0]  mem_width;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .BIG_ENDIAN(BE)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .mem_width_i (mem_width),
    .sign_ext_i  (sign_ext),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .done_o      (done),
    .misalign_o  (misalign),
    .err_o       (err),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_be_o    (bus_be),
    .bus_wdata_o (bus_wdata),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lane_of(input int j);
    return (BE != 0) ? 3 - j : j;
  endfunction

  task automatic drop_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_width = 2'b00;
    sign_ext  = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
  endtask

  // One complete access; ack_at = BUSY cycle (1-based) carrying the ack, 0 = never.
  task automatic access(input bit rd, input bit wr, input logic [1:0] w, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int ack_at);
    int          k, nbytes, exp_req, exp_stall, stalls, reqs, done_at;
    bit          mis, tmo;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, v;
    logic [7:0]  b [4];

    k      = int'(a[1:0]);
    nbytes = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    mis    = (k % nbytes) != 0;
    tmo    = (ack_at == 0) || (ack_at > T);
    exp_be = 4'b0000;
    for (int j = 0; j < 4; j++) b[j] = 8'((rword >> (8 * lane_of(j))) & 32'hFF);
    v = 32'd0;
    if (!mis) begin
      for (int i = 0; i < nbytes; i++) begin
        exp_be[lane_of(k + i)] = 1'b1;
        if (BE != 0) v = v | (32'(b[k + i]) << (8 * (nbytes - 1 - i)));
        else         v = v | (32'(b[k + i]) << (8 * i));
      end
    end
    if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
    exp_wd    = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
    exp_rd    = (mis || wr || tmo) ? 32'd0 : v;
    exp_req   = mis ? 0 : (tmo ? T : ack_at);
    exp_stall = 1 + exp_req;

    stalls  = 0;
    reqs    = 0;
    done_at = -1;
    @(posedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    mem_width = w;
    sign_ext  = sgn;
    addr      = a;
    wdata     = wd;
    for (int cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        done_at = cyc;
        chk("misalign", 32'(misalign), 32'(mis));
        chk("err", 32'(err), 32'(tmo && !mis));
        chk("rdata", rdata, exp_rd);
        chk("req_in_done", 32'(bus_req), 32'd0);
      end else if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          chk("bus_addr", bus_addr, {a[31:2], 2'b00});
          chk("bus_we", 32'(bus_we), 32'(wr));
          chk("bus_be", 32'(bus_be), 32'(exp_be));
          chk("bus_wdata", bus_wdata, exp_wd);
        end
        if (reqs == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = rword;
        end
      end else begin
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    chk("done_seen", 32'(done_at >= 0), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("req_cycles", 32'(reqs), 32'(exp_req));
    chk("done_latency", 32'(done_at), 32'(exp_stall));
    drop_inputs();
    @(negedge clk);
    chk("no_reissue_req", 32'(bus_req), 32'd0);
    chk("no_reissue_done", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reqs;
    rst       = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    drop_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {30'd0, misalign, err}, 32'd0);
    chk("rst_bus", {bus_we, bus_be, bus_addr[26:0]}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(1, 0, 2'b10, 0, 32'h100, 32'd0, 32'hDEADBEEF, 3);
    access(1, 0, 2'b00, 1, 32'h103, 32'd0, 32'h80123456, 1);
    access(1, 0, 2'b00, 0, 32'h103, 32'd0, 32'h80123456, 2);
    access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h5555AAAA, 1);
    access(1, 0, 2'b10, 0, 32'h101, 32'd0, 32'h11111111, 1);
    access(1, 0, 2'b10, 0, 32'h104, 32'd0, 32'hCAFEF00D, 0);
    access(1, 0, 2'b01, 1, 32'h202, 32'd0, 32'h8001FFFF, 4);
    access(1, 1, 2'b00, 0, 32'h301, 32'hA5A5A5C3, 32'h12345678, 2);
    access(1, 0, 2'b01, 0, 32'h305, 32'd0, 32'h0, 1);

    // Reset in the second BUSY cycle aborts without done_o.
    @(posedge clk); #1;
    mem_read  = 1'b1;
    mem_width = 2'b10;
    addr      = 32'h400;
    reqs      = 0;
    for (int cyc = 0; cyc < 10 && reqs < 2; cyc++) begin
      @(negedge clk);
      if (bus_req) reqs++;
      if (reqs == 2) rst = 1'b1;
    end
    chk("rst_busy_reached", 32'(reqs), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    drop_inputs();
    @(negedge clk);
    chk("rst_abort_req", 32'(bus_req), 32'd0);
    chk("rst_abort_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_abort_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    access(1, 0, 2'b10, 0, 32'h400, 32'd0, 32'h0BADCAFE, 1);

    for (int n = 0; n < 60; n++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, T + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
